// File: rtl/mano_io_ctrl.sv
// mano_io_ctrl: device-side I/O controller for a Mano-style basic computer.
//   - Input path: DEPTH-entry FIFO from an input device to the CPU's INPR, with FGI.
//   - Output path: three-state handshake FSM from OUTR to an output device, with FGO.
//   - Interrupt enable flip-flop (IEN) and the combinational IRQ request.
// Optional build macro: MANO_IO_LOOPBACK_EN adds input LPBK, which routes
// output bytes back into the input FIFO instead of the output device.
module mano_io_ctrl #(
  parameter int DEPTH     = 4,
  parameter int OUT_DELAY = 3
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       DEV_IN_VALID,
  input  logic [7:0] DEV_IN_DATA,
  output logic       DEV_IN_READY,
  output logic [7:0] INPR_DATA,
  output logic       FGI,
  input  logic       INP_ACK,
  input  logic [7:0] OUTR_DATA,
  input  logic       OUT_STB,
  output logic       FGO,
  output logic       DEV_OUT_VALID,
  output logic [7:0] DEV_OUT_DATA,
  input  logic       DEV_OUT_READY,
  input  logic       ION,
  input  logic       IOF,
  input  logic       INT_ACK,
  output logic       IEN,
  output logic       IRQ,
  output logic       OVR
`ifdef MANO_IO_LOOPBACK_EN
  ,
  input  logic       LPBK
`endif
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;
  localparam int CW    = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CW-1:0]    DLY_LOAD = CW'(OUT_DELAY - 1);

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_SEND = 2'd1,
    O_BUSY = 2'd2
  } out_state_e;

  // Loopback select; constant 0 when the feature is not built in
  logic lpbk;
`ifdef MANO_IO_LOOPBACK_EN
  assign lpbk = LPBK;
`else
  assign lpbk = 1'b0;
`endif

  // ---------------- Input FIFO state ----------------
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       head_q, head_d;

  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [7:0]       push_data;
  logic [CNT_W-1:0] cnt_after_pop;

  // ---------------- Output path state ----------------
  out_state_e       state_q, state_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CW-1:0]    dly_q, dly_d;
  logic             ovr_q, ovr_d;
  logic             lb_push;

  // ---------------- Interrupt enable ----------------
  logic             ien_q, ien_d;

  assign fifo_full    = (count_q == FULL_CNT);
  assign DEV_IN_READY = !fifo_full;
  assign FGI          = (count_q != '0);
  assign INPR_DATA    = head_q;

  // Push source: the output byte in loopback mode, the input device otherwise
  always_comb begin
    push      = 1'b0;
    push_data = DEV_IN_DATA;
    if (lpbk) begin
      push      = lb_push;
      push_data = out_data_q;
    end else begin
      push      = DEV_IN_VALID && !fifo_full;
      push_data = DEV_IN_DATA;
    end
  end

  assign pop = INP_ACK && (count_q != '0);

  // FIFO pointer/count update and registered head-of-queue byte
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    head_d        = head_q;
    cnt_after_pop = count_q - CNT_W'(pop);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = cnt_after_pop + CNT_W'(push);

    // When the queue would otherwise be empty, the incoming byte becomes the head
    if (count_d == '0) begin
      head_d = 8'h00;
    end else if (cnt_after_pop == '0) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage: data only, no reset needed
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // FIFO control registers
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Output FSM next-state, data capture, busy countdown and overrun flag
  always_comb begin
    state_d       = state_q;
    out_data_d    = out_data_q;
    dly_d         = dly_q;
    ovr_d         = ovr_q;
    lb_push       = 1'b0;
    DEV_OUT_VALID = 1'b0;

    unique case (state_q)
      O_IDLE: begin
        if (OUT_STB) begin
          out_data_d = OUTR_DATA;
          state_d    = O_SEND;
        end
      end
      O_SEND: begin
        if (lpbk) begin
          // Byte goes into the input FIFO once there is room
          if (!fifo_full) begin
            lb_push = 1'b1;
            dly_d   = DLY_LOAD;
            state_d = O_BUSY;
          end
        end else begin
          DEV_OUT_VALID = 1'b1;
          if (DEV_OUT_READY) begin
            dly_d   = DLY_LOAD;
            state_d = O_BUSY;
          end
        end
      end
      O_BUSY: begin
        if (dly_q == '0) begin
          state_d = O_IDLE;
        end else begin
          dly_d = dly_q - CW'(1);
        end
      end
      default: begin
        state_d = O_IDLE;
      end
    endcase

    // A strobe while the output path is occupied is dropped and flagged
    if (OUT_STB && (state_q != O_IDLE)) ovr_d = 1'b1;
  end

  // Output FSM registers
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= O_IDLE;
      out_data_q <= 8'h00;
      dly_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      dly_q      <= dly_d;
      ovr_q      <= ovr_d;
    end
  end

  assign FGO          = (state_q == O_IDLE);
  assign DEV_OUT_DATA = out_data_q;
  assign OVR          = ovr_q;

  // IEN next state: clears win over set
  always_comb begin
    ien_d = ien_q;
    if (INT_ACK || IOF) begin
      ien_d = 1'b0;
    end else if (ION) begin
      ien_d = 1'b1;
    end
  end

  // IEN register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ien_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
    end
  end

  assign IEN = ien_q;
  assign IRQ = ien_q & (FGI | FGO);

endmodule

// File: tb/tb_mano_io_ctrl.sv
// Directed testbench for mano_io_ctrl (DEPTH=4, OUT_DELAY=3).
module tb_mano_io_ctrl;

  logic       CLK;
  logic       CLR;
  logic       DEV_IN_VALID;
  logic [7:0] DEV_IN_DATA;
  logic       DEV_IN_READY;
  logic [7:0] INPR_DATA;
  logic       FGI;
  logic       INP_ACK;
  logic [7:0] OUTR_DATA;
  logic       OUT_STB;
  logic       FGO;
  logic       DEV_OUT_VALID;
  logic [7:0] DEV_OUT_DATA;
  logic       DEV_OUT_READY;
  logic       ION;
  logic       IOF;
  logic       INT_ACK;
  logic       IEN;
  logic       IRQ;
  logic       OVR;
`ifdef MANO_IO_LOOPBACK_EN
  logic       LPBK;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mano_io_ctrl #(.DEPTH(4), .OUT_DELAY(3)) dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .DEV_IN_VALID  (DEV_IN_VALID),
    .DEV_IN_DATA   (DEV_IN_DATA),
    .DEV_IN_READY  (DEV_IN_READY),
    .INPR_DATA     (INPR_DATA),
    .FGI           (FGI),
    .INP_ACK       (INP_ACK),
    .OUTR_DATA     (OUTR_DATA),
    .OUT_STB       (OUT_STB),
    .FGO           (FGO),
    .DEV_OUT_VALID (DEV_OUT_VALID),
    .DEV_OUT_DATA  (DEV_OUT_DATA),
    .DEV_OUT_READY (DEV_OUT_READY),
    .ION           (ION),
    .IOF           (IOF),
    .INT_ACK       (INT_ACK),
    .IEN           (IEN),
    .IRQ           (IRQ),
    .OVR           (OVR)
`ifdef MANO_IO_LOOPBACK_EN
    ,
    .LPBK          (LPBK)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    CLR = 1'b0; DEV_IN_VALID = 1'b0; DEV_IN_DATA = 8'h00; INP_ACK = 1'b0;
    OUTR_DATA = 8'h00; OUT_STB = 1'b0; DEV_OUT_READY = 1'b0;
    ION = 1'b0; IOF = 1'b0; INT_ACK = 1'b0;
`ifdef MANO_IO_LOOPBACK_EN
    LPBK = 1'b0;
`endif

    // Reset values
    tick(); tick();
    chk("rst_fgi", FGI, 0);
    chk("rst_inpr", INPR_DATA, 8'h00);
    chk("rst_ready", DEV_IN_READY, 1);
    chk("rst_fgo", FGO, 1);
    chk("rst_oval", DEV_OUT_VALID, 0);
    chk("rst_odata", DEV_OUT_DATA, 8'h00);
    chk("rst_ien", IEN, 0);
    chk("rst_irq", IRQ, 0);
    chk("rst_ovr", OVR, 0);
    CLR = 1'b1;
    tick();

    // Input: push 0x41, 0x42, then pop both
    DEV_IN_VALID = 1'b1; DEV_IN_DATA = 8'h41; tick();
    chk("in1_fgi", FGI, 1);
    chk("in1_inpr", INPR_DATA, 8'h41);
    DEV_IN_DATA = 8'h42; tick();
    DEV_IN_VALID = 1'b0;
    chk("in2_inpr", INPR_DATA, 8'h41);
    INP_ACK = 1'b1; tick();
    chk("ack1_inpr", INPR_DATA, 8'h42);
    chk("ack1_fgi", FGI, 1);
    tick();
    chk("ack2_fgi", FGI, 0);
    chk("ack2_inpr", INPR_DATA, 8'h00);
    tick();  // INP_ACK while empty is ignored
    INP_ACK = 1'b0;
    chk("ackemp_fgi", FGI, 0);
    chk("ackemp_ready", DEV_IN_READY, 1);

    // Fill to DEPTH and hold a fifth byte
    DEV_IN_VALID = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      DEV_IN_DATA = 8'(i);
      chk("fill_ready", DEV_IN_READY, 1);
      tick();
    end
    chk("full_ready", DEV_IN_READY, 0);
    chk("full_inpr", INPR_DATA, 8'h01);
    DEV_IN_DATA = 8'h05; tick(); tick();
    chk("hold_ready", DEV_IN_READY, 0);
    chk("hold_inpr", INPR_DATA, 8'h01);
    INP_ACK = 1'b1;
    chk("fullpop_ready", DEV_IN_READY, 0);
    tick();  // pop only; held byte not taken this edge
    INP_ACK = 1'b0;
    chk("pop3_inpr", INPR_DATA, 8'h02);
    chk("pop3_ready", DEV_IN_READY, 1);
    tick();  // held 0x05 enters, full again
    DEV_IN_VALID = 1'b0;
    chk("refull_ready", DEV_IN_READY, 0);
    INP_ACK = 1'b1; tick();
    chk("pop_inpr", INPR_DATA, 8'h03);
    DEV_IN_VALID = 1'b1; DEV_IN_DATA = 8'h06; tick();  // simultaneous push/pop at count 3
    DEV_IN_VALID = 1'b0;
    chk("pp_inpr", INPR_DATA, 8'h04);
    chk("pp_ready", DEV_IN_READY, 1);
    tick();
    chk("drain1", INPR_DATA, 8'h05);
    tick();
    chk("drain2", INPR_DATA, 8'h06);
    tick();
    INP_ACK = 1'b0;
    chk("drain_fgi", FGI, 0);

    // Output with READY tied high
    DEV_OUT_READY = 1'b1; OUTR_DATA = 8'h5A; OUT_STB = 1'b1; tick();
    OUT_STB = 1'b0;
    chk("out_fgo0", FGO, 0);
    chk("out_data", DEV_OUT_DATA, 8'h5A);
    chk("out_valid", DEV_OUT_VALID, 1);
    tick();
    chk("out_busy_valid", DEV_OUT_VALID, 0);
    chk("out_fgo_c2", FGO, 0);
    tick();
    chk("out_fgo_c3", FGO, 0);
    tick();
    chk("out_fgo_c4", FGO, 0);
    tick();
    chk("out_fgo_c5", FGO, 1);
    chk("out_ovr", OVR, 0);

    // Output stalled by device, then overrun
    DEV_OUT_READY = 1'b0; OUT_STB = 1'b1; tick();
    OUT_STB = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", DEV_OUT_VALID, 1);
      chk("stall_data", DEV_OUT_DATA, 8'h5A);
      chk("stall_fgo", FGO, 0);
      tick();
    end
    OUTR_DATA = 8'hA5; OUT_STB = 1'b1; tick();
    OUT_STB = 1'b0;
    chk("ovr_set", OVR, 1);
    chk("ovr_data", DEV_OUT_DATA, 8'h5A);
    DEV_OUT_READY = 1'b1;
    tick(); tick(); tick();
    chk("ovr_fgo_busy", FGO, 0);
    tick();
    chk("ovr_fgo_done", FGO, 1);
    chk("ovr_sticky", OVR, 1);

    // Interrupt enable and IRQ
    chk("int_irq0", IRQ, 0);
    ION = 1'b1; tick(); ION = 1'b0;
    chk("ion_ien", IEN, 1);
    chk("ion_irq_fgo", IRQ, 1);
    DEV_OUT_READY = 1'b0; OUTR_DATA = 8'h11; OUT_STB = 1'b1; tick();
    OUT_STB = 1'b0;
    chk("irq_nofl", IRQ, 0);
    DEV_IN_VALID = 1'b1; DEV_IN_DATA = 8'h21; tick();
    DEV_IN_VALID = 1'b0;
    chk("irq_fgi", IRQ, 1);
    INT_ACK = 1'b1; ION = 1'b1; tick();
    INT_ACK = 1'b0; ION = 1'b0;
    chk("intack_ien", IEN, 0);
    chk("intack_irq", IRQ, 0);
    ION = 1'b1; tick(); ION = 1'b0;
    chk("ion2_ien", IEN, 1);
    IOF = 1'b1; ION = 1'b1; tick();
    IOF = 1'b0; ION = 1'b0;
    chk("iof_ien", IEN, 0);
    ION = 1'b1; tick(); ION = 1'b0;

    // Asynchronous reset mid-transfer
    CLR = 1'b0; #1;
    chk("mid_fgo", FGO, 1);
    chk("mid_oval", DEV_OUT_VALID, 0);
    chk("mid_odata", DEV_OUT_DATA, 8'h00);
    chk("mid_fgi", FGI, 0);
    chk("mid_inpr", INPR_DATA, 8'h00);
    chk("mid_ovr", OVR, 0);
    chk("mid_ien", IEN, 0);
    CLR = 1'b1;
    tick();
    chk("post_fgo", FGO, 1);

`ifdef MANO_IO_LOOPBACK_EN
    // Loopback: output byte re-enters the input FIFO
    LPBK = 1'b1; DEV_OUT_READY = 1'b0;
    DEV_IN_VALID = 1'b1; DEV_IN_DATA = 8'h77;
    OUTR_DATA = 8'h33; OUT_STB = 1'b1; tick();
    OUT_STB = 1'b0;
    chk("lb_valid1", DEV_OUT_VALID, 0);
    chk("lb_fgi0", FGI, 0);
    tick();
    chk("lb_valid2", DEV_OUT_VALID, 0);
    chk("lb_fgi", FGI, 1);
    chk("lb_inpr", INPR_DATA, 8'h33);
    tick(); tick(); tick();
    chk("lb_fgo", FGO, 1);
    DEV_IN_VALID = 1'b0; INP_ACK = 1'b1; tick();
    INP_ACK = 1'b0;
    chk("lb_drain", FGI, 0);
    LPBK = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
